spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- Parametrised successor to the fixed 8-bit, mode-0 SPI slave.
- Adds configurable word width, all four CPOL/CPHA modes and MSB/LSB-first ordering.
- Adds metastability synchronisers, an async reset, a MISO output-enable and detection of aborted frames.
- Sits between an external SPI master and the fabric's `clk` domain. It oversamples `sck`, `mosi` and `ssel` and exchanges words through one-cycle pulse handshakes.

Parameters:
- DATA_WIDTH, 8, bits per word (2..32).
- CPOL, 0, `sck` idle level.
- CPHA, 0, 0 = sample on the leading edge; 1 = sample on the trailing edge.
- MSB_FIRST, 1, 1 = shift MSB first; 0 = shift LSB first.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (≥2).

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock from the master (asynchronous).
- mosi  in  1  master-out data (asynchronous).
- ssel  in  1  active-low slave select (asynchronous).
- miso  out  1  slave-out data bit.
- misoOe  out  1  high while selected; enable for an external tristate.
- byteReceived  out  1  one-clk pulse when a full word has been received.
- receivedData  out  DATA_WIDTH  last completed word; held until the next word completes.
- dataNeeded  out  1  one-clk pulse requesting the next TX word.
- dataToSend  in  DATA_WIDTH  TX word; sampled in the cycle `dataNeeded` is high.
- busy  out  1  high while selected (synchronised `ssel` low).
- frameAbort  out  1  one-clk pulse when `ssel` deasserts mid-word.

Behaviour:
- **Reset** (async, active-high): all registers clear; synchroniser chains load the idle values (`sck` = CPOL, `ssel` = 1, `mosi` = 0).
  - All outputs read 0 during reset: `miso`, `misoOe`, `byteReceived`, `receivedData`, `dataNeeded`, `busy`, `frameAbort`.
  - Reset asserted mid-frame discards the partial word. After release, the block waits for a fresh `ssel` falling edge; a frame already in progress is ignored until `ssel` rises and falls again.
- **Synchronisers:** `sck`, `mosi` and `ssel` each pass through SYNC_STAGES flip-flops.
  - Edges are detected from the last two synchronised samples.
  - Master constraints: `sck` high and low phases each ≥ SYNC_STAGES+2 clk cycles; `ssel` assert to first `sck` edge ≥ SYNC_STAGES+3 clk cycles.
- **Edges:** leading = transition from the CPOL level; trailing = transition back to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Shift edge = the other edge.
- **State machine:**
  - IDLE: on synchronised `ssel` falling edge → `dataNeeded` pulses one cycle; `txBuf` ← `dataToSend` in that same cycle; bitCount ← 0; armed ← 0; → ACTIVE.
  - ACTIVE, sample edge: shift the synchronised `mosi` into `rxShift` (MSB_FIRST selects which end); bitCount++; armed ← 1.
  - ACTIVE, shift edge with armed = 1: advance `txBuf` by one bit.
  - ACTIVE, shift edge with armed = 0: ignored. This keeps bit 0 valid for CPHA=1, and for CPHA=0 suppresses the trailing edge that follows a word boundary.
  - ACTIVE, sample edge that makes bitCount = DATA_WIDTH, all on the next clk:
    - `receivedData` ← completed word; `byteReceived` pulses.
    - `dataNeeded` pulses; `txBuf` ← `dataToSend`.
    - bitCount ← 0; armed ← 0.
    - The block stays in ACTIVE, so back-to-back words need no gap.
  - ACTIVE, `ssel` rising edge: → IDLE. If bitCount ≠ 0, `frameAbort` pulses and the partial word is dropped; `receivedData` is unchanged.
- **Simultaneous events:** an `ssel` rising edge in the same clk as a sample edge is treated as deselect; that sample is not taken.
- **MISO:**
  - `miso` = `txBuf[DATA_WIDTH-1]` if MSB_FIRST, else `txBuf[0]`.
  - `miso` reads 0 and `misoOe` = 0 when not busy.
  - `busy` = `misoOe` = synchronised `ssel` low.
- `dataToSend` is only sampled in a `dataNeeded` cycle. Combinational or same-cycle-registered responses are both legal.

Test Plan:
- **Mode 0 (defaults):** `dataToSend` = 0xFF in the first `dataNeeded` cycle and 0x00 in the second; MOSI 0xFF then 0x00 back-to-back → two `byteReceived` pulses with `receivedData` = 0xFF then 0x00; master captures 0xFF then 0x00 on MISO; three `dataNeeded` pulses in total.
- **DATA_WIDTH=16, CPOL=1, CPHA=1:** MOSI 0xA55A; `dataToSend` = 0x1234 → `receivedData` = 0xA55A; master captures 0x1234; `byteReceived` exactly once.
- **MSB_FIRST=0, mode 0:** MOSI bit stream 1,0,0,0,0,0,0,0 → `receivedData` = 0x01; `dataToSend` = 0x80 → master sees 0,0,0,0,0,0,0,1.
- **Abort:** `ssel` deasserted after 5 sample edges → `frameAbort` pulses once; no `byteReceived`; `receivedData` keeps its prior value; `busy` falls.
- **Reset mid-word:** `rst` pulsed after 3 bits → all outputs 0 immediately (async); the rest of that frame is ignored; the next full frame with MOSI 0x3C → `receivedData` = 0x3C.
- **Idle checks:** toggling `sck` with `ssel` high → no pulses and `misoOe` = 0. Separately, `ssel` asserted, wait 100 clk with no `sck` edges → exactly one `dataNeeded` pulse.

Source files
------------

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parametrised SPI slave (width, CPOL/CPHA, bit order) in the clk domain
// Oversamples sck/mosi/ssel through synchronisers and exchanges words via one-cycle pulses.
module spi_slave_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  ssel,
    output logic                  miso,
    output logic                  misoOe,
    output logic                  byteReceived,
    output logic [DATA_WIDTH-1:0] receivedData,
    output logic                  dataNeeded,
    input  logic [DATA_WIDTH-1:0] dataToSend,
    output logic                  busy,
    output logic                  frameAbort
);

    localparam int             CW       = $clog2(DATA_WIDTH + 1);
    localparam logic           SCK_IDLE = (CPOL != 0);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} stateType;

    stateType state, stateNext;

    logic [SYNC_STAGES-1:0] sckChain, mosiChain, sselChain, validChain;
    logic sckPrev, sselPrev, sselReady;
    logic sckS, mosiS, sselS;
    logic leadingEdge, trailingEdge, sampleEdge, shiftEdge, sselFall, sselRise;
    logic startFrame, sampleEn, wordDone, shiftEn, abortNow;
    logic [CW-1:0]         bitCount;
    logic                  armed;
    logic [DATA_WIDTH-1:0] rxShift, rxNext, txBuf;

    // validChain marks when sselS carries a real post-reset sample, so a frame
    // already running at reset release is not mistaken for a fresh select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sckChain   <= {SYNC_STAGES{SCK_IDLE}};
            mosiChain  <= '0;
            sselChain  <= '1;
            validChain <= '0;
            sckPrev    <= SCK_IDLE;
            sselPrev   <= 1'b1;
            sselReady  <= 1'b0;
        end else begin
            sckChain   <= {sckChain[SYNC_STAGES-2:0], sck};
            mosiChain  <= {mosiChain[SYNC_STAGES-2:0], mosi};
            sselChain  <= {sselChain[SYNC_STAGES-2:0], ssel};
            validChain <= {validChain[SYNC_STAGES-2:0], 1'b1};
            sckPrev    <= sckS;
            sselPrev   <= sselS;
            if (validChain[SYNC_STAGES-1] && sselS) begin
                sselReady <= 1'b1;
            end
        end
    end

    assign sckS  = sckChain[SYNC_STAGES-1];
    assign mosiS = mosiChain[SYNC_STAGES-1];
    assign sselS = sselChain[SYNC_STAGES-1];

    assign leadingEdge  = (sckPrev == SCK_IDLE) && (sckS != SCK_IDLE);
    assign trailingEdge = (sckPrev != SCK_IDLE) && (sckS == SCK_IDLE);
    assign sampleEdge   = (CPHA != 0) ? trailingEdge : leadingEdge;
    assign shiftEdge    = (CPHA != 0) ? leadingEdge : trailingEdge;
    assign sselFall     = sselReady && sselPrev && !sselS;
    assign sselRise     = !sselPrev && sselS;

    assign busy   = sselReady && !sselS;
    assign misoOe = busy;
    assign miso   = busy && ((MSB_FIRST != 0) ? txBuf[DATA_WIDTH-1] : txBuf[0]);
    assign rxNext = (MSB_FIRST != 0) ? {rxShift[DATA_WIDTH-2:0], mosiS}
                                     : {mosiS, rxShift[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Deselect wins over a coincident sample edge.
    always_comb begin
        stateNext  = state;
        startFrame = 1'b0;
        sampleEn   = 1'b0;
        wordDone   = 1'b0;
        shiftEn    = 1'b0;
        abortNow   = 1'b0;
        case (state)
            IDLE: begin
                if (sselFall) begin
                    stateNext  = ACTIVE;
                    startFrame = 1'b1;
                end
            end
            ACTIVE: begin
                if (sselRise) begin
                    stateNext = IDLE;
                    abortNow  = (bitCount != '0);
                end else if (sampleEdge) begin
                    sampleEn = 1'b1;
                    wordDone = (bitCount == LAST_BIT);
                end else if (shiftEdge && armed) begin
                    shiftEn = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCount     <= '0;
            armed        <= 1'b0;
            rxShift      <= '0;
            txBuf        <= '0;
            receivedData <= '0;
            byteReceived <= 1'b0;
            dataNeeded   <= 1'b0;
            frameAbort   <= 1'b0;
        end else begin
            byteReceived <= wordDone;
            dataNeeded   <= startFrame || wordDone;
            frameAbort   <= abortNow;
            if (startFrame || wordDone) begin
                bitCount <= '0;
                armed    <= 1'b0;
            end else if (sampleEn) begin
                bitCount <= bitCount + CW'(1);
                armed    <= 1'b1;
            end
            if (sampleEn) begin
                rxShift <= rxNext;
            end
            if (wordDone) begin
                receivedData <= rxNext;
            end
            if (dataNeeded) begin
                txBuf <= dataToSend;
            end else if (shiftEn) begin
                txBuf <= (MSB_FIRST != 0) ? (txBuf << 1) : (txBuf >> 1);
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - directed bench for spi_slave_param in three configurations
module tb_spi_slave_param;

    localparam int H = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] sck, mosi, ssel;
    wire  [2:0] miso, misoOe, byteReceived, dataNeeded, busy, frameAbort;
    logic [7:0]  tx0, tx2;
    logic [15:0] tx1;
    wire  [7:0]  rxd0, rxd2;
    wire  [15:0] rxd1;

    int checks = 0;
    int errors = 0;

    int br0 = 0, dn0 = 0, fa0 = 0, br1 = 0, dn1 = 0, br2 = 0, dn2 = 0;
    logic [7:0] rxLog0 [0:7];

    always #5 clk = ~clk;

    spi_slave_param dut0 (
        .clk(clk), .rst(rst), .sck(sck[0]), .mosi(mosi[0]), .ssel(ssel[0]),
        .miso(miso[0]), .misoOe(misoOe[0]), .byteReceived(byteReceived[0]),
        .receivedData(rxd0), .dataNeeded(dataNeeded[0]), .dataToSend(tx0),
        .busy(busy[0]), .frameAbort(frameAbort[0])
    );

    spi_slave_param #(.DATA_WIDTH(16), .CPOL(1), .CPHA(1)) dut1 (
        .clk(clk), .rst(rst), .sck(sck[1]), .mosi(mosi[1]), .ssel(ssel[1]),
        .miso(miso[1]), .misoOe(misoOe[1]), .byteReceived(byteReceived[1]),
        .receivedData(rxd1), .dataNeeded(dataNeeded[1]), .dataToSend(tx1),
        .busy(busy[1]), .frameAbort(frameAbort[1])
    );

    spi_slave_param #(.MSB_FIRST(0)) dut2 (
        .clk(clk), .rst(rst), .sck(sck[2]), .mosi(mosi[2]), .ssel(ssel[2]),
        .miso(miso[2]), .misoOe(misoOe[2]), .byteReceived(byteReceived[2]),
        .receivedData(rxd2), .dataNeeded(dataNeeded[2]), .dataToSend(tx2),
        .busy(busy[2]), .frameAbort(frameAbort[2])
    );

    always @(negedge clk) begin
        if (byteReceived[0]) begin
            rxLog0[br0[2:0]] <= rxd0;
            br0 <= br0 + 1;
        end
        if (dataNeeded[0])   dn0 <= dn0 + 1;
        if (frameAbort[0])   fa0 <= fa0 + 1;
        if (byteReceived[1]) br1 <= br1 + 1;
        if (dataNeeded[1])   dn1 <= dn1 + 1;
        if (byteReceived[2]) br2 <= br2 + 1;
        if (dataNeeded[2])   dn2 <= dn2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycle-level SPI master: drives nbits of txWord and captures miso at each master sample point.
    task automatic xfer(input int idx, input bit cpol, input bit cpha, input int width,
                        input int nbits, input bit msbFirst, input logic [31:0] txWord,
                        output logic [31:0] rxWord);
        rxWord = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = msbFirst ? (width - 1 - i) : i;
            if (!cpha) begin
                mosi[idx] = txWord[b];
                waitClk(H);
                rxWord[b] = miso[idx];
                sck[idx] = ~cpol;
                waitClk(H);
                sck[idx] = cpol;
            end else begin
                sck[idx] = ~cpol;
                mosi[idx] = txWord[b];
                waitClk(H);
                rxWord[b] = miso[idx];
                sck[idx] = cpol;
                waitClk(H);
            end
        end
    endtask

    initial begin
        int b0, d0, f0, b1, d1, b2, idx;
        logic [31:0] r, r2;
        logic oeBad;

        sck  = 3'b010;
        mosi = 3'b000;
        ssel = 3'b111;
        tx0  = 8'h00;
        tx1  = 16'h0000;
        tx2  = 8'h00;

        waitClk(3);
        check("rst_miso", miso[0], 0);
        check("rst_misoOe", misoOe[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_rxData0", rxd0, 0);
        check("rst_rxData1", rxd1, 0);
        check("rst_pulses", {byteReceived, dataNeeded, frameAbort}, 0);
        rst = 1'b0;
        waitClk(5);
        check("idle_busy", busy[0], 0);
        check("idle_misoOe", misoOe[0], 0);

        // Mode 0, two back-to-back words
        b0 = br0; d0 = dn0; f0 = fa0;
        tx0 = 8'hFF;
        ssel[0] = 1'b0;
        waitClk(8);
        check("m0_busy", busy[0], 1);
        check("m0_misoOe", misoOe[0], 1);
        tx0 = 8'h00;
        xfer(0, 1'b0, 1'b0, 8, 8, 1'b1, 32'hFF, r);
        xfer(0, 1'b0, 1'b0, 8, 8, 1'b1, 32'h00, r2);
        waitClk(8);
        ssel[0] = 1'b1;
        waitClk(8);
        check("m0_brCount", br0 - b0, 2);
        idx = b0 & 7;
        check("m0_rx1", rxLog0[idx], 8'hFF);
        idx = (b0 + 1) & 7;
        check("m0_rx2", rxLog0[idx], 8'h00);
        check("m0_miso1", r, 32'hFF);
        check("m0_miso2", r2, 32'h00);
        check("m0_dnCount", dn0 - d0, 3);
        check("m0_noAbort", fa0 - f0, 0);
        check("m0_busyEnd", busy[0], 0);

        // 16-bit, CPOL=1, CPHA=1
        b1 = br1; d1 = dn1;
        tx1 = 16'h1234;
        ssel[1] = 1'b0;
        waitClk(8);
        xfer(1, 1'b1, 1'b1, 16, 16, 1'b1, 32'hA55A, r);
        waitClk(8);
        ssel[1] = 1'b1;
        waitClk(8);
        check("m3_rxData", rxd1, 16'hA55A);
        check("m3_miso", r, 32'h1234);
        check("m3_brCount", br1 - b1, 1);
        check("m3_dnCount", dn1 - d1, 2);

        // LSB first, mode 0
        b2 = br2;
        tx2 = 8'h80;
        ssel[2] = 1'b0;
        waitClk(8);
        xfer(2, 1'b0, 1'b0, 8, 8, 1'b0, 32'h01, r);
        waitClk(8);
        ssel[2] = 1'b1;
        waitClk(8);
        check("lsb_rxData", rxd2, 8'h01);
        check("lsb_miso", r, 32'h80);
        check("lsb_brCount", br2 - b2, 1);

        // Mode 0 reference frame, then an aborted frame
        tx0 = 8'h5A;
        ssel[0] = 1'b0;
        waitClk(8);
        xfer(0, 1'b0, 1'b0, 8, 8, 1'b1, 32'hA5, r);
        waitClk(8);
        ssel[0] = 1'b1;
        waitClk(8);
        check("ref_rxData", rxd0, 8'hA5);
        check("ref_miso", r, 32'h5A);
        b0 = br0; f0 = fa0;
        tx0 = 8'hFF;
        ssel[0] = 1'b0;
        waitClk(8);
        xfer(0, 1'b0, 1'b0, 8, 5, 1'b1, 32'hFF, r);
        waitClk(2);
        ssel[0] = 1'b1;
        waitClk(8);
        check("abort_faCount", fa0 - f0, 1);
        check("abort_noByte", br0 - b0, 0);
        check("abort_rxKept", rxd0, 8'hA5);
        check("abort_busy", busy[0], 0);

        // Reset in the middle of a word
        tx0 = 8'hFF;
        ssel[0] = 1'b0;
        waitClk(8);
        xfer(0, 1'b0, 1'b0, 8, 3, 1'b1, 32'hFF, r);
        waitClk(2);
        check("prerst_miso", miso[0], 1);
        #2 rst = 1'b1;
        #1;
        check("mrst_miso", miso[0], 0);
        check("mrst_misoOe", misoOe[0], 0);
        check("mrst_busy", busy[0], 0);
        check("mrst_rxData", rxd0, 0);
        check("mrst_pulses", {byteReceived[0], dataNeeded[0], frameAbort[0]}, 0);
        waitClk(3);
        rst = 1'b0;
        b0 = br0; d0 = dn0; f0 = fa0;
        xfer(0, 1'b0, 1'b0, 8, 5, 1'b1, 32'hFF, r);
        waitClk(8);
        ssel[0] = 1'b1;
        waitClk(8);
        check("ign_noByte", br0 - b0, 0);
        check("ign_noNeed", dn0 - d0, 0);
        check("ign_noAbort", fa0 - f0, 0);
        ssel[0] = 1'b0;
        waitClk(8);
        xfer(0, 1'b0, 1'b0, 8, 8, 1'b1, 32'h3C, r);
        waitClk(8);
        ssel[0] = 1'b1;
        waitClk(8);
        check("post_rxData", rxd0, 8'h3C);
        check("post_brCount", br0 - b0, 1);

        // sck activity while deselected
        b0 = br0; d0 = dn0; f0 = fa0;
        oeBad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sck[0] = ~sck[0];
            for (int j = 0; j < H; j++) begin
                @(negedge clk);
                oeBad = oeBad | misoOe[0] | busy[0];
            end
        end
        check("desel_oe", oeBad, 0);
        check("desel_br", br0 - b0, 0);
        check("desel_dn", dn0 - d0, 0);
        check("desel_fa", fa0 - f0, 0);

        // Selected with no sck edges
        ssel[0] = 1'b0;
        waitClk(100);
        check("sel_dnOnce", dn0 - d0, 1);
        check("sel_busy", busy[0], 1);
        ssel[0] = 1'b1;
        waitClk(8);
        check("sel_noAbort", fa0 - f0, 0);
        check("sel_noByte", br0 - b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
